track_timer: RTL and testbench
==============================

# track_timer

Parametrised playback-position timer for the music player. Keeps the track position as a binary seconds count, advances it by a signed step on each tick while `count` is high, and supports seek (load), end-of-track limit, and wrap or saturate modes. Drives BCD digits for the `driver7seg` instances through a multi-cycle binary-to-mm:ss converter.

## Interface
- `MIN_DIGITS`, 2: number of BCD minute digits; MAX_SEC = 60·10^MIN_DIGITS − 1 (5999 by default).
- `POS_W`, 13: width of the binary position; must hold MAX_SEC.
- `STEP_W`, 9: width of the signed step `adder`; 2^(STEP_W−1) ≤ MAX_SEC+1.
- `WRAP`, 0: 1 = position wraps modulo MAX_SEC+1; 0 = position saturates at 0 and at the limit.
- Derived: MBIN_W = clog2(10^MIN_DIGITS) (7 by default); CONV_LAT = POS_W + MBIN_W + 1 (21 by default).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  1-cycle step enable (1 Hz strobe in system).
- `count`  in  1  run/pause; steps applied only when high.
- `adder`  in  STEP_W  signed two's-complement step in seconds.
- `load`  in  1  seek strobe.
- `load_value`  in  POS_W  seek target, binary seconds.
- `limit`  in  POS_W  end-of-track position (WRAP=0 only).
- `position`  out  POS_W  current binary position.
- `seconds0`, `seconds1`  out  4  BCD seconds units/tens.
- `minutes`  out  4·MIN_DIGITS  BCD minutes; minutes0 in [3:0].
- `busy`  out  1  conversion in progress.
- `at_start`, `at_end`  out  1  levels: position==0 / position==eff_limit.
- `end_pulse`  out  1  1-cycle pulse when position becomes eff_limit.

## Operation
- Reset: position, all digits, busy, at_end, end_pulse = 0; at_start = 1; converter IDLE.
- Priority per edge: reset > load > (tick & count) step.
- eff_limit = min(limit, MAX_SEC) when WRAP=0, MAX_SEC when WRAP=1.
- Step: next = position + sign-extended adder, computed at POS_W+1 signed width.
  - WRAP=1: next < 0 → next + MAX_SEC+1; next > MAX_SEC → next − (MAX_SEC+1). One correction suffices.
  - WRAP=0: clamp to [0, eff_limit]. A position already above eff_limit (after a limit change) clamps down on the next step.
- Load: position = min(load_value, MAX_SEC); ignores `count`; load_value above eff_limit is clamped when WRAP=0.
- end_pulse: fires on the edge where position changes to eff_limit from any other value, including by load. Not repeated while position holds. Never fires when WRAP=1 unless a load targets MAX_SEC or a step lands on it.
- Converter FSM: IDLE → DIV → BCD → IDLE.
  - DIV: restoring division of the latched position by 60, POS_W cycles; yields minutes (MBIN_W bits) and seconds 0..59.
  - BCD: shift-add-3 of the minutes, MBIN_W cycles. Seconds are split into tens/units by the same pass or a parallel small converter.
  - Final cycle: write all digits together.
- Conversion start: on any edge where position changes value. If busy, the converter aborts and restarts from the new position; digits keep their old values until a conversion completes.
- A step of 0, or a clamp that leaves position unchanged, does not start a conversion.

## Timing
- position, at_start, at_end, end_pulse update on the same edge as tick/load, so they are valid one cycle after the strobe.
- busy rises on the edge position changes. Digits update and busy falls exactly CONV_LAT edges later (21 by default), with no intervening change.
- Ticks must be spaced ≥ CONV_LAT+1 cycles for every position to be displayed. Closer spacing is legal; digits show only the last settled position.
- Reset mid-conversion: next edge forces IDLE and zeroes all outputs per the reset values.
- Digits are always a consistent mm:ss snapshot; no partial updates.

## Test plan
- Reset; count=1, adder=1, tick every 32 cycles, 75 ticks → position=75, digits 01:15, busy=0; busy high exactly 21 cycles after each tick.
- At 01:15 set count=0, 10 ticks → position/digits unchanged, busy never rises; count=1 → resumes 01:16.
- WRAP=0, position=5, adder=−9'd10, one tick → position=0, at_start=1, digits 00:00; another tick → no change, busy stays 0.
- WRAP=0, limit=90, position=85, adder=8 → position=90, end_pulse high one cycle, at_end=1; further ticks → no change, no pulse.
- WRAP=1: load 5999, adder=1, tick → position=0; adder=−1, tick → 5999, digits 99:59.
- load 3725 at cycle 5 of a conversion → restart, digits 62:05 exactly 21 cycles after load; reset asserted mid-conversion → all outputs 0, at_start=1 on the next edge.

Source files
------------

// File: rtl/track_timer.sv
// track_timer: playback position counter with seek, end-of-track limit and
// wrap/saturate stepping, plus a sequential binary-to-mm:ss BCD converter.
module track_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int POS_W      = 13,
  parameter int STEP_W     = 9,
  parameter bit WRAP       = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      count,
  input  logic signed [STEP_W-1:0]  adder,
  input  logic                      load,
  input  logic [POS_W-1:0]          load_value,
  input  logic [POS_W-1:0]          limit,
  output logic [POS_W-1:0]          position,
  output logic [3:0]                seconds0,
  output logic [3:0]                seconds1,
  output logic [4*MIN_DIGITS-1:0]   minutes,
  output logic                      busy,
  output logic                      at_start,
  output logic                      at_end,
  output logic                      end_pulse
);
  localparam int MAX_SEC = 60 * (10 ** MIN_DIGITS) - 1;
  localparam int MBIN_W  = $clog2(10 ** MIN_DIGITS);
  localparam int BCD_W   = 4 * MIN_DIGITS;
  localparam int CNT_W   = $clog2(POS_W + 1);

  localparam logic [POS_W-1:0]        MAX_POS  = POS_W'(MAX_SEC);
  localparam logic signed [POS_W:0]   MAX_S    = (POS_W+1)'(MAX_SEC);
  localparam logic signed [POS_W:0]   SPAN_S   = (POS_W+1)'(MAX_SEC + 1);
  localparam logic [CNT_W-1:0]        DIV_LAST = CNT_W'(POS_W - 1);
  localparam logic [CNT_W-1:0]        BCD_LAST = CNT_W'(MBIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_BCD, S_FIN} state_t;

  // Saturating step: clamp the widened sum into [0, hi].
  function automatic logic [POS_W-1:0] sat_pos(input logic signed [POS_W:0] v,
                                               input logic [POS_W-1:0] hi);
    if (v < 0)
      return '0;
    else if (v > $signed({1'b0, hi}))
      return hi;
    else
      return POS_W'(v);
  endfunction

  // Modulo step: the step magnitude is below one span, so a single correction is enough.
  function automatic logic [POS_W-1:0] wrap_pos(input logic signed [POS_W:0] v);
    logic signed [POS_W:0] r;
    r = v;
    if (v < 0)
      r = v + SPAN_S;
    else if (v > MAX_S)
      r = v - SPAN_S;
    return POS_W'(r);
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < MIN_DIGITS; i++)
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Seconds are at most 59, so five conditional subtractions split tens/units.
  function automatic logic [7:0] sec_bcd(input logic [5:0] s);
    logic [3:0] t;
    logic [5:0] u;
    t = 4'd0;
    u = s;
    for (int k = 0; k < 5; k++)
      if (u >= 6'd10) begin
        u = u - 6'd10;
        t = t + 4'd1;
      end
    return {t, 4'(u)};
  endfunction

  logic [POS_W-1:0]        eff_limit;
  logic signed [POS_W:0]   sum;
  logic [POS_W-1:0]        pos_nxt;
  logic                    pos_chg;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [POS_W-1:0]        div_q;
  logic [5:0]              rem;
  logic [MBIN_W-1:0]       bin;
  logic [BCD_W-1:0]        bcd;

  logic [6:0]              rem_sh;
  logic                    qbit;
  logic [5:0]              rem_nxt;
  logic [POS_W-1:0]        div_q_nxt;

  always_comb begin
    if (WRAP)
      eff_limit = MAX_POS;
    else
      eff_limit = (limit > MAX_POS) ? MAX_POS : limit;
    sum = $signed({1'b0, position})
        + $signed({{(POS_W+1-STEP_W){adder[STEP_W-1]}}, adder});
    pos_nxt = position;
    if (load)
      pos_nxt = (load_value > eff_limit) ? eff_limit : load_value;
    else if (tick && count)
      pos_nxt = WRAP ? wrap_pos(sum) : sat_pos(sum, eff_limit);
    pos_chg = (pos_nxt != position);
  end

  // Restoring divide-by-60: one dividend bit per cycle, MSB first.
  always_comb begin
    rem_sh    = {rem, div_q[POS_W-1]};
    qbit      = (rem_sh >= 7'd60);
    rem_nxt   = qbit ? 6'(rem_sh - 7'd60) : rem_sh[5:0];
    div_q_nxt = {div_q[POS_W-2:0], qbit};
  end

  // Control, position flags and the digit snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      position  <= '0;
      at_start  <= 1'b1;
      at_end    <= 1'b0;
      end_pulse <= 1'b0;
      busy      <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
      seconds0  <= '0;
      seconds1  <= '0;
      minutes   <= '0;
    end else begin
      position  <= pos_nxt;
      at_start  <= (pos_nxt == '0);
      at_end    <= (pos_nxt == eff_limit);
      end_pulse <= pos_chg && (pos_nxt == eff_limit);
      if (pos_chg) begin
        state <= S_DIV;
        busy  <= 1'b1;
        cnt   <= '0;
      end else begin
        case (state)
          S_DIV: begin
            cnt <= cnt + 1'b1;
            if (cnt == DIV_LAST) begin
              state <= S_BCD;
              cnt   <= '0;
            end
          end
          S_BCD: begin
            cnt <= cnt + 1'b1;
            if (cnt == BCD_LAST) begin
              state <= S_FIN;
              cnt   <= '0;
            end
          end
          S_FIN: begin
            minutes              <= bcd;
            {seconds1, seconds0} <= sec_bcd(rem);
            busy                 <= 1'b0;
            state                <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Converter datapath; every conversion reinitialises it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pos_chg) begin
      div_q <= pos_nxt;
      rem   <= '0;
    end else if (state == S_DIV) begin
      div_q <= div_q_nxt;
      rem   <= rem_nxt;
      if (cnt == DIV_LAST) begin
        bin <= div_q_nxt[MBIN_W-1:0];
        bcd <= '0;
      end
    end else if (state == S_BCD) begin
      bcd <= (add3(bcd) << 1) | BCD_W'(bin[MBIN_W-1]);
      bin <= bin << 1;
    end
  end

endmodule

// File: tb/tb_track_timer.sv
// Directed bench for track_timer: one saturating (WRAP=0) and one wrapping (WRAP=1)
// instance share stimulus; a select picks which one the checks observe.
module tb_track_timer;
  logic               clk;
  logic               reset;
  logic               tick;
  logic               count;
  logic signed [8:0]  adder;
  logic               load;
  logic [12:0]        load_value;
  logic [12:0]        limit;
  logic               sel;

  logic [12:0] pos_a, pos_b;
  logic [3:0]  s0_a, s1_a, s0_b, s1_b;
  logic [7:0]  min_a, min_b;
  logic        busy_a, busy_b, as_a, as_b, ae_a, ae_b, ep_a, ep_b;

  logic [31:0] o_pos, o_dig, o_busy, o_as, o_ae, o_ep;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_pos, obs_busy, obs_ep, obs_ep0, obs_start, obs_end, obs_d20, obs_d21;

  track_timer #(.MIN_DIGITS(2), .POS_W(13), .STEP_W(9), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .tick(tick), .count(count), .adder(adder),
    .load(load), .load_value(load_value), .limit(limit), .position(pos_a),
    .seconds0(s0_a), .seconds1(s1_a), .minutes(min_a), .busy(busy_a),
    .at_start(as_a), .at_end(ae_a), .end_pulse(ep_a)
  );

  track_timer #(.MIN_DIGITS(2), .POS_W(13), .STEP_W(9), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .tick(tick), .count(count), .adder(adder),
    .load(load), .load_value(load_value), .limit(limit), .position(pos_b),
    .seconds0(s0_b), .seconds1(s1_b), .minutes(min_b), .busy(busy_b),
    .at_start(as_b), .at_end(ae_b), .end_pulse(ep_b)
  );

  assign o_pos  = sel ? 32'(pos_b) : 32'(pos_a);
  assign o_dig  = sel ? 32'({min_b, s1_b, s0_b}) : 32'({min_a, s1_a, s0_a});
  assign o_busy = sel ? 32'(busy_b) : 32'(busy_a);
  assign o_as   = sel ? 32'(as_b) : 32'(as_a);
  assign o_ae   = sel ? 32'(ae_b) : 32'(ae_a);
  assign o_ep   = sel ? 32'(ep_b) : 32'(ep_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mmss(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return 32'({4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observe 31 samples following a strobe edge (sample i is taken after edge E_i).
  task automatic window();
    obs_busy = 0;
    obs_ep   = 0;
    for (int i = 0; i < 31; i++) begin
      if (i == 0) begin
        obs_pos   = int'(o_pos);
        obs_ep0   = int'(o_ep);
        obs_start = int'(o_as);
        obs_end   = int'(o_ae);
      end
      if (i == 20) obs_d20 = int'(o_dig);
      if (i == 21) obs_d21 = int'(o_dig);
      if (o_busy[0]) obs_busy++;
      if (o_ep[0]) obs_ep++;
      cyc(1);
    end
  endtask

  task automatic strobe(input logic ld, input logic tk, input logic [12:0] lv);
    load       = ld;
    tick       = tk;
    load_value = lv;
    cyc(1);
    load = 1'b0;
    tick = 1'b0;
    window();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; count = 1'b0; adder = '0;
    load = 1'b0; load_value = '0; limit = 13'd5999; sel = 1'b0;
    cyc(2);
    chk("rst_pos", o_pos, 0);
    chk("rst_dig", o_dig, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_at_start", o_as, 1);
    chk("rst_at_end", o_ae, 0);
    chk("rst_end_pulse", o_ep, 0);
    reset = 1'b0;

    // Count up 75 seconds, one tick per 32 cycles
    count = 1'b1;
    adder = 9'sd1;
    for (int n = 1; n <= 75; n++) begin
      strobe(1'b0, 1'b1, '0);
      chk("run_pos", obs_pos, n);
      chk("run_busy_len", obs_busy, 21);
      chk("run_dig_e20", obs_d20, mmss(n - 1));
      chk("run_dig_e21", obs_d21, mmss(n));
    end
    chk("run_final_dig", o_dig, 'h0115);
    chk("run_final_busy", o_busy, 0);

    // Paused: ticks ignored
    count = 1'b0;
    for (int n = 0; n < 10; n++) begin
      strobe(1'b0, 1'b1, '0);
      chk("pause_pos", obs_pos, 75);
      chk("pause_busy", obs_busy, 0);
      chk("pause_dig", obs_d21, 'h0115);
    end
    count = 1'b1;
    strobe(1'b0, 1'b1, '0);
    chk("resume_pos", obs_pos, 76);
    chk("resume_dig", obs_d21, 'h0116);

    // Saturate at zero
    strobe(1'b1, 1'b0, 13'd5);
    chk("seek5_pos", obs_pos, 5);
    chk("seek5_dig", obs_d21, 'h0005);
    adder = -9'sd10;
    strobe(1'b0, 1'b1, '0);
    chk("sat0_pos", obs_pos, 0);
    chk("sat0_at_start", obs_start, 1);
    chk("sat0_busy_len", obs_busy, 21);
    chk("sat0_dig_e20", obs_d20, 'h0005);
    chk("sat0_dig_e21", obs_d21, 'h0000);
    strobe(1'b0, 1'b1, '0);
    chk("sat0_hold_pos", obs_pos, 0);
    chk("sat0_hold_busy", obs_busy, 0);

    // Saturate at the limit
    limit = 13'd90;
    strobe(1'b1, 1'b0, 13'd85);
    chk("seek85_pos", obs_pos, 85);
    chk("seek85_pulse", obs_ep, 0);
    chk("seek85_at_end", obs_end, 0);
    chk("seek85_dig", obs_d21, 'h0125);
    adder = 9'sd8;
    strobe(1'b0, 1'b1, '0);
    chk("lim_pos", obs_pos, 90);
    chk("lim_pulse_e0", obs_ep0, 1);
    chk("lim_pulse_cnt", obs_ep, 1);
    chk("lim_at_end", obs_end, 1);
    chk("lim_dig", obs_d21, 'h0130);
    strobe(1'b0, 1'b1, '0);
    chk("lim_hold_pos", obs_pos, 90);
    chk("lim_hold_pulse", obs_ep, 0);
    chk("lim_hold_busy", obs_busy, 0);
    chk("lim_hold_at_end", obs_end, 1);
    limit = 13'd80;
    strobe(1'b0, 1'b1, '0);
    chk("lim_lower_pos", obs_pos, 80);
    chk("lim_lower_pulse", obs_ep0, 1);
    chk("lim_lower_dig", obs_d21, 'h0120);
    strobe(1'b1, 1'b0, 13'd200);
    chk("seek_over_pos", obs_pos, 80);
    chk("seek_over_busy", obs_busy, 0);
    chk("seek_over_pulse", obs_ep, 0);

    // Wrapping instance
    sel = 1'b1;
    strobe(1'b1, 1'b0, 13'd5999);
    chk("wrap_seek_pos", obs_pos, 5999);
    chk("wrap_seek_pulse", obs_ep0, 1);
    chk("wrap_seek_dig", obs_d21, 'h9959);
    adder = 9'sd1;
    strobe(1'b0, 1'b1, '0);
    chk("wrap_up_pos", obs_pos, 0);
    chk("wrap_up_at_start", obs_start, 1);
    chk("wrap_up_dig", obs_d21, 'h0000);
    adder = -9'sd1;
    strobe(1'b0, 1'b1, '0);
    chk("wrap_dn_pos", obs_pos, 5999);
    chk("wrap_dn_at_end", obs_end, 1);
    chk("wrap_dn_pulse", obs_ep0, 1);
    chk("wrap_dn_dig", obs_d21, 'h9959);
    adder = 9'sd255;
    strobe(1'b0, 1'b1, '0);
    chk("wrap_big_pos", obs_pos, 254);
    chk("wrap_big_dig", obs_d21, 'h0414);
    chk("wrap_big_pulse", obs_ep, 0);

    // Seek during a conversion restarts it
    sel   = 1'b0;
    limit = 13'd5999;
    strobe(1'b1, 1'b0, 13'd100);
    chk("seek100_dig", obs_d21, 'h0140);
    load_value = 13'd200;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(4);
    chk("restart_busy_mid", o_busy, 1);
    chk("restart_dig_mid", o_dig, 'h0140);
    strobe(1'b1, 1'b0, 13'd3725);
    chk("restart_pos", obs_pos, 3725);
    chk("restart_busy_len", obs_busy, 21);
    chk("restart_dig_e20", obs_d20, 'h0140);
    chk("restart_dig_e21", obs_d21, 'h6205);

    // Reset in the middle of a conversion
    load_value = 13'd10;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_pos", o_pos, 0);
    chk("rst_mid_dig", o_dig, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_at_start", o_as, 1);
    chk("rst_mid_at_end", o_ae, 0);
    chk("rst_mid_pulse", o_ep, 0);
    reset = 1'b0;
    cyc(25);
    chk("rst_after_busy", o_busy, 0);
    chk("rst_after_dig", o_dig, 0);
    chk("rst_after_pos", o_pos, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
